// File: rtl/rv32i_encoder.sv
// rtl/rv32i_encoder.sv - RV32I field-bundle to machine-word encoder with 2-entry output FIFO
// Optional M-extension encodings are enabled by defining RV32M_EN.
module rv32i_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  iclass,
    input  logic [5:0]  alucode,
    input  logic [4:0]  dstreg_num,
    input  logic [4:0]  srcreg1_num,
    input  logic [4:0]  srcreg2_num,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_err,
    output logic [7:0]  err_cnt
);
    localparam logic [5:0] ALU_ADD  = 6'd1,  ALU_SUB  = 6'd2,  ALU_SLL  = 6'd3,  ALU_SLT  = 6'd4;
    localparam logic [5:0] ALU_SLTU = 6'd5,  ALU_XOR  = 6'd6,  ALU_SRL  = 6'd7,  ALU_SRA  = 6'd8;
    localparam logic [5:0] ALU_OR   = 6'd9,  ALU_AND  = 6'd10, ALU_BEQ  = 6'd11, ALU_BNE  = 6'd12;
    localparam logic [5:0] ALU_BLT  = 6'd13, ALU_BGE  = 6'd14, ALU_BLTU = 6'd15, ALU_BGEU = 6'd16;
    localparam logic [5:0] ALU_LB   = 6'd17, ALU_LH   = 6'd18, ALU_LW   = 6'd19, ALU_LBU  = 6'd20;
    localparam logic [5:0] ALU_LHU  = 6'd21, ALU_SB   = 6'd22, ALU_SH   = 6'd23, ALU_SW   = 6'd24;
`ifdef RV32M_EN
    localparam logic [5:0] ALU_MUL  = 6'd25, ALU_REMU = 6'd32;
`endif
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        legal, is_shift;
    logic        i_ok, b_ok, j_ok;
    logic [31:0] word;

    assign i_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_ok = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign j_ok = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

    // Shared ALU funct3 decode for OP/OP-IMM; SUB is rejected later for OP-IMM.
    always_comb begin
        f3       = 3'd0;
        f7       = 7'd0;
        legal    = 1'b1;
        is_shift = 1'b0;
        case (alucode)
            ALU_ADD:  f3 = 3'b000;
            ALU_SUB:  begin f3 = 3'b000; f7 = 7'b0100000; end
            ALU_SLL:  begin f3 = 3'b001; is_shift = 1'b1; end
            ALU_SLT:  f3 = 3'b010;
            ALU_SLTU: f3 = 3'b011;
            ALU_XOR:  f3 = 3'b100;
            ALU_SRL:  begin f3 = 3'b101; is_shift = 1'b1; end
            ALU_SRA:  begin f3 = 3'b101; f7 = 7'b0100000; is_shift = 1'b1; end
            ALU_OR:   f3 = 3'b110;
            ALU_AND:  f3 = 3'b111;
            default:  legal = 1'b0;
        endcase
    end

    logic [2:0]  g3;
    logic        g_legal;
    logic        enc_legal;
    always_comb begin
        g3        = 3'd0;
        g_legal   = 1'b1;
        enc_legal = 1'b1;
        word      = NOP_WORD;
        case (iclass)
            4'd0: begin
                enc_legal = legal & (alucode != ALU_SUB) & (is_shift ? ~(|imm[31:5]) : i_ok);
                word = is_shift ? {f7, imm[4:0], srcreg1_num, f3, dstreg_num, 7'b0010011}
                                : {imm[11:0], srcreg1_num, f3, dstreg_num, 7'b0010011};
            end
            4'd1: begin
                enc_legal = legal;
                word = {f7, srcreg2_num, srcreg1_num, f3, dstreg_num, 7'b0110011};
`ifdef RV32M_EN
                if (alucode >= ALU_MUL && alucode <= ALU_REMU) begin
                    enc_legal = 1'b1;
                    word = {7'b0000001, srcreg2_num, srcreg1_num, 3'(alucode - ALU_MUL),
                            dstreg_num, 7'b0110011};
                end
`endif
            end
            4'd2: begin
                enc_legal = ~(|imm[11:0]);
                word = {imm[31:12], dstreg_num, 7'b0110111};
            end
            4'd3: begin
                enc_legal = ~(|imm[11:0]);
                word = {imm[31:12], dstreg_num, 7'b0010111};
            end
            4'd4: begin
                enc_legal = j_ok;
                word = {imm[20], imm[10:1], imm[11], imm[19:12], dstreg_num, 7'b1101111};
            end
            4'd5: begin
                enc_legal = i_ok;
                word = {imm[11:0], srcreg1_num, 3'b000, dstreg_num, 7'b1100111};
            end
            4'd6: begin
                case (alucode)
                    ALU_BEQ:  g3 = 3'b000;
                    ALU_BNE:  g3 = 3'b001;
                    ALU_BLT:  g3 = 3'b100;
                    ALU_BGE:  g3 = 3'b101;
                    ALU_BLTU: g3 = 3'b110;
                    ALU_BGEU: g3 = 3'b111;
                    default:  g_legal = 1'b0;
                endcase
                enc_legal = g_legal & b_ok;
                word = {imm[12], imm[10:5], srcreg2_num, srcreg1_num, g3, imm[4:1], imm[11], 7'b1100011};
            end
            4'd7: begin
                case (alucode)
                    ALU_LB:  g3 = 3'b000;
                    ALU_LH:  g3 = 3'b001;
                    ALU_LW:  g3 = 3'b010;
                    ALU_LBU: g3 = 3'b100;
                    ALU_LHU: g3 = 3'b101;
                    default: g_legal = 1'b0;
                endcase
                enc_legal = g_legal & i_ok;
                word = {imm[11:0], srcreg1_num, g3, dstreg_num, 7'b0000011};
            end
            4'd8: begin
                case (alucode)
                    ALU_SB:  g3 = 3'b000;
                    ALU_SH:  g3 = 3'b001;
                    ALU_SW:  g3 = 3'b010;
                    default: g_legal = 1'b0;
                endcase
                enc_legal = g_legal & i_ok;
                word = {imm[11:5], srcreg2_num, srcreg1_num, g3, imm[4:0], 7'b0100011};
            end
            default: enc_legal = 1'b0;
        endcase
    end

    logic [32:0] new_entry;
    assign new_entry = enc_legal ? {1'b0, word} : {1'b1, NOP_WORD};

    logic [1:0]  count_q, count_d;
    logic [32:0] head_q, head_d, tail_q, tail_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_word  = head_q[31:0];
    assign out_err   = head_q[32];
    assign err_cnt   = err_cnt_q;

    always_comb begin
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;
        err_cnt_d = err_cnt_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = new_entry;
                else                 tail_d = new_entry;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            // Simultaneous push/pop only happens at occupancy 1, so the new word becomes head.
            2'b11:   head_d = new_entry;
            default: ;
        endcase
        if (push && !enc_legal && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= 2'd0;
            head_q    <= 33'd0;
            tail_q    <= 33'd0;
            err_cnt_q <= 8'd0;
        end else begin
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            err_cnt_q <= err_cnt_d;
        end
    end
endmodule

// File: tb/tb_rv32i_encoder.sv
// tb/tb_rv32i_encoder.sv - scoreboard testbench for rv32i_encoder
module tb_rv32i_encoder;
    localparam logic [5:0] ALU_ADD = 6'd1, ALU_SUB = 6'd2, ALU_SRA = 6'd8, ALU_BEQ = 6'd11;
    localparam logic [5:0] ALU_LW = 6'd19, ALU_SW = 6'd24, ALU_MUL = 6'd25;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready;
    logic [3:0]  iclass = '0;
    logic [5:0]  alucode = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        out_valid, out_ready = 1'b1, out_err;
    logic [31:0] out_word;
    logic [7:0]  err_cnt;

    rv32i_encoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .iclass(iclass), .alucode(alucode), .dstreg_num(rd), .srcreg1_num(rs1),
        .srcreg2_num(rs2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0, exp_errs = 0;
    logic [32:0] sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_unexpected_word", out_word, 32'hxxxx_xxxx);
            else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("out_word", out_word, e[31:0]);
                check("out_err", {31'd0, out_err}, {31'd0, e[32]});
            end
        end
    end

    task automatic send(input logic [3:0] ic, input logic [5:0] alu, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                        input logic [31:0] ew, input logic ee);
        bit ok = 1'b0;
        iclass = ic; alucode = alu; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        else begin
            sb.push_back({ee, ew});
            if (ee && exp_errs < 255) exp_errs++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        send(4'd0, ALU_ADD, 5'd1, 5'd2, 5'd0, 32'd5, 32'h0051_0093, 1'b0);
        check("addi_latency_valid", {31'd0, out_valid}, 32'd1);
        send(4'd1, ALU_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
        send(4'd6, ALU_BEQ, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 1'b0);
        send(4'd0, ALU_SRA, 5'd1, 5'd2, 5'd0, 32'd3, 32'h4031_5093, 1'b0);
        send(4'd2, ALU_ADD, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        send(4'd4, 6'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 1'b0);
        send(4'd8, ALU_SW, 5'd0, 5'd1, 5'd2, 32'd12, 32'h0020_A623, 1'b0);
        send(4'd7, ALU_LW, 5'd3, 5'd2, 5'd0, 32'hFFFF_FFFC, 32'hFFC1_2183, 1'b0);
        check("err_cnt_clean", {24'd0, err_cnt}, 32'd0);

        send(4'd0, ALU_ADD, 5'd1, 5'd2, 5'd0, 32'd2048, NOP, 1'b1);
        check("err_cnt_addi_range", {24'd0, err_cnt}, 32'd1);
        send(4'd6, ALU_BEQ, 5'd0, 5'd1, 5'd2, 32'd7, NOP, 1'b1);
        check("err_cnt_beq_odd", {24'd0, err_cnt}, 32'd2);
        send(4'd0, ALU_SRA, 5'd1, 5'd2, 5'd0, 32'd32, NOP, 1'b1);
        send(4'd0, ALU_SUB, 5'd1, 5'd2, 5'd0, 32'd1, NOP, 1'b1);
        check("err_cnt_opimm", {24'd0, err_cnt}, 32'd4);
`ifdef RV32M_EN
        send(4'd1, ALU_MUL, 5'd5, 5'd6, 5'd7, 32'd0, 32'h0273_02B3, 1'b0);
        check("err_cnt_mul", {24'd0, err_cnt}, 32'd4);
`else
        send(4'd1, ALU_MUL, 5'd5, 5'd6, 5'd7, 32'd0, NOP, 1'b1);
        check("err_cnt_mul", {24'd0, err_cnt}, 32'd5);
`endif

        for (int i = 0; i < 300; i++)
            send(4'(9 + (i % 7)), ALU_ADD, 5'd1, 5'd1, 5'd1, 32'd0, NOP, 1'b1);
        check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
        check("err_cnt_model", {24'd0, err_cnt}, exp_errs);

        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4'd0, ALU_ADD, 5'd1, 5'd0, 5'd0, 32'd1, 32'h0010_0093, 1'b0);
        send(4'd0, ALU_ADD, 5'd2, 5'd0, 5'd0, 32'd2, 32'h0020_0113, 1'b0);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        fork
            send(4'd0, ALU_ADD, 5'd3, 5'd0, 5'd0, 32'd3, 32'h0030_0193, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_held_in_ready", {31'd0, in_ready}, 32'd0);
                check("bp_out_valid", {31'd0, out_valid}, 32'd1);
                out_ready = 1'b1;
            end
        join
        for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
        #1;
        check("bp_drained", sb.size(), 32'd0);

        out_ready = 1'b0;
        send(4'd0, ALU_ADD, 5'd4, 5'd0, 5'd0, 32'd4, 32'h0040_0213, 1'b0);
        send(4'd9, ALU_ADD, 5'd4, 5'd0, 5'd0, 32'd4, NOP, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_errs = 0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("midrst_out_word", out_word, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(4'd1, ALU_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 1'b0);
        check("postrst_valid", {31'd0, out_valid}, 32'd1);
        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        #1;
        check("final_drained", sb.size(), 32'd0);
        check("final_err_cnt", {24'd0, err_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
